// File: rtl/det_matrix_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : det_pkg
// Brief    : Shared sizes, state encoding and slot-to-bit mapping for the
//            3x3 determinant matrix loader.
// Revision : 1.0  initial release
// ============================================================================
package det_pkg;

    localparam int ELEM_W      = 32;
    localparam int N           = 3;
    localparam int NUM_SLOTS   = N * N;
    localparam int MATRIX_W    = NUM_SLOTS * ELEM_W;
    localparam int DET_LATENCY = 2;
    localparam int CNT_W       = $clog2(NUM_SLOTS);
    localparam int WAIT_W      = (DET_LATENCY > 1) ? $clog2(DET_LATENCY) : 1;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        WAIT   = 2'd1,
        RESULT = 2'd2
    } state_t;

    // Slot 0 (E[0][0]) occupies the most significant element of the bus.
    function automatic int unsigned slot_lsb(input int unsigned slot);
        return (NUM_SLOTS - 1 - slot) * ELEM_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/det_matrix_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : det_matrix_loader_if
// Brief    : Element stream, matrix bus and determinant return signals.
// Revision : 1.0  initial release
// ============================================================================
interface det_matrix_loader_if;
    import det_pkg::*;

    logic [ELEM_W-1:0]   elem_data;
    logic                elem_valid;
    logic                elem_ready;
    logic [MATRIX_W-1:0] matrix_out;
    logic                matrix_valid;
    logic [ELEM_W-1:0]   det_in;
    logic [ELEM_W-1:0]   det_out;
    logic                det_valid;
    logic                det_ready;

    modport master (
        output elem_data, elem_valid, det_in, det_ready,
        input  elem_ready, matrix_out, matrix_valid, det_out, det_valid
    );

    modport slave (
        input  elem_data, elem_valid, det_in, det_ready,
        output elem_ready, matrix_out, matrix_valid, det_out, det_valid
    );

endinterface
`default_nettype wire

// File: rtl/det_matrix_loader.sv
`default_nettype none
// ============================================================================
// Module   : det_matrix_loader
// Brief    : Packs nine streamed elements into the calculator's matrix bus,
//            waits out its latency and returns the determinant.
// Revision : 1.0  initial release
// ============================================================================
module det_matrix_loader
    import det_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          reset,
    det_matrix_loader_if.slave bus
);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    elem_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [MATRIX_W-1:0] matrix_q;
    logic [ELEM_W-1:0]   det_q;

    logic accept;
    logic last_slot;
    logic wait_done;
    logic elem_ready;
    logic matrix_valid;
    logic det_valid;

    assign accept    = (state == LOAD) && bus.elem_valid;
    assign last_slot = (elem_cnt == CNT_W'(NUM_SLOTS - 1));
    assign wait_done = (wait_cnt == WAIT_W'(DET_LATENCY - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (accept && last_slot) state_nxt = WAIT;
            WAIT:    if (wait_done)           state_nxt = RESULT;
            RESULT:  if (bus.det_ready)       state_nxt = LOAD;
            default:                          state_nxt = LOAD;
        endcase
    end

    // Handshake outputs are forced low for as long as reset is held.
    always_comb begin
        elem_ready   = 1'b0;
        matrix_valid = 1'b0;
        det_valid    = 1'b0;
        if (reset) begin
            case (state)
                LOAD:   elem_ready = 1'b1;
                WAIT:   matrix_valid = 1'b1;
                RESULT: begin
                    matrix_valid = 1'b1;
                    det_valid    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            elem_cnt <= '0;
            wait_cnt <= '0;
            matrix_q <= '0;
            det_q    <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        for (int s = 0; s < NUM_SLOTS; s++) begin
                            if (elem_cnt == CNT_W'(s)) begin
                                matrix_q[slot_lsb(s) +: ELEM_W] <= bus.elem_data;
                            end
                        end
                        if (last_slot) begin
                            elem_cnt <= '0;
                            wait_cnt <= '0;
                        end else begin
                            elem_cnt <= elem_cnt + CNT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (wait_done) begin
                        det_q    <= bus.det_in;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.elem_ready   = elem_ready;
    assign bus.matrix_valid = matrix_valid;
    assign bus.det_valid    = det_valid;
    assign bus.matrix_out   = matrix_q;
    assign bus.det_out      = det_q;

endmodule
`default_nettype wire

// File: tb/tb_det_matrix_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_det_matrix_loader
// Brief    : Directed self-checking bench for det_matrix_loader with a
//            behavioural determinant calculator downstream.
// Revision : 1.0  initial release
// ============================================================================
module tb_det_matrix_loader;
    import det_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    det_matrix_loader_if bus ();

    det_matrix_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Downstream calculator: one register stage, active-high reset.
    function automatic logic [31:0] det3(input logic [MATRIX_W-1:0] m);
        logic [31:0] e [9];
        for (int i = 0; i < 9; i++) e[i] = m[(8 - i) * 32 +: 32];
        return e[0] * (e[4] * e[8] - e[5] * e[7])
             - e[1] * (e[3] * e[8] - e[5] * e[6])
             + e[2] * (e[3] * e[7] - e[4] * e[6]);
    endfunction

    logic        calc_rst;
    logic [31:0] calc_q;
    assign calc_rst = ~reset;

    always_ff @(posedge clk or posedge calc_rst) begin
        if (calc_rst) calc_q <= '0;
        else          calc_q <= det3(bus.matrix_out);
    end

    assign bus.det_in = calc_q;

    task automatic check(input string tag, input logic [MATRIX_W-1:0] obs,
                         input logic [MATRIX_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load9(input logic [31:0] e [9], input bit gapped);
        for (int i = 0; i < 9; i++) begin
            if (gapped && i > 0) begin
                bus.elem_valid = 1'b0;
                bus.elem_data  = 32'hDEAD_BEEF;
                tick();
                tick();
            end
            bus.elem_valid = 1'b1;
            bus.elem_data  = e[i];
            for (int t = 0; t < 20 && !bus.elem_ready; t++) tick();
            if (!bus.elem_ready) begin
                checks++;
                errors++;
                $error("FAIL elem_ready timeout: observed 0 expected 1");
            end
            tick();
        end
        bus.elem_valid = 1'b0;
        bus.elem_data  = '0;
    endtask

    task automatic run(input string name, input logic [31:0] e [9],
                       input bit gapped, input bit pre_ready, input int hold,
                       input logic [31:0] exp_det);
        logic [MATRIX_W-1:0] exp_m;
        exp_m = {e[0], e[1], e[2], e[3], e[4], e[5], e[6], e[7], e[8]};
        bus.det_ready = pre_ready;
        load9(e, gapped);
        check({name, " matrix_out"},   bus.matrix_out, exp_m);
        check({name, " matrix_valid"}, bus.matrix_valid, 1);
        check({name, " elem_ready wait"}, bus.elem_ready, 0);
        check({name, " det_valid +1"}, bus.det_valid, 0);
        tick();
        check({name, " det_valid +2"}, bus.det_valid, 0);
        tick();
        check({name, " det_valid +3"}, bus.det_valid, 1);
        check({name, " det_out"},      bus.det_out, exp_det);
        for (int h = 0; h < hold; h++) begin
            tick();
            check({name, " hold det_valid"},  bus.det_valid, 1);
            check({name, " hold det_out"},    bus.det_out, exp_det);
            check({name, " hold matrix_out"}, bus.matrix_out, exp_m);
            check({name, " hold elem_ready"}, bus.elem_ready, 0);
        end
        bus.det_ready = 1'b1;
        tick();
        check({name, " done det_valid"},    bus.det_valid, 0);
        check({name, " done matrix_valid"}, bus.matrix_valid, 0);
        check({name, " done elem_ready"},   bus.elem_ready, 1);
        bus.det_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v [9];
        bus.elem_data  = '0;
        bus.elem_valid = 1'b0;
        bus.det_ready  = 1'b0;
        #2 reset = 1'b0;
        tick();
        tick();
        check("reset elem_ready",   bus.elem_ready, 0);
        check("reset matrix_valid", bus.matrix_valid, 0);
        check("reset det_valid",    bus.det_valid, 0);
        check("reset matrix_out",   bus.matrix_out, 0);
        check("reset det_out",      bus.det_out, 0);
        reset = 1'b1;
        tick();
        check("post-reset elem_ready", bus.elem_ready, 1);

        v = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1};
        run("identity", v, 1'b0, 1'b0, 5, 32'd1);

        v = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
        run("packing", v, 1'b0, 1'b1, 0, 32'd0);

        v = '{32'd2, 32'd0, 32'd0, 32'd0, 32'd3, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFC};
        run("diagonal", v, 1'b0, 1'b0, 1, 32'hFFFF_FFE8);
        run("gapped", v, 1'b1, 1'b0, 0, 32'hFFFF_FFE8);

        bus.elem_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.elem_data = 32'd7 + 32'(i);
            tick();
        end
        reset = 1'b0;
        #1;
        check("midreset matrix_out",   bus.matrix_out, 0);
        check("midreset det_out",      bus.det_out, 0);
        check("midreset elem_ready",   bus.elem_ready, 0);
        check("midreset matrix_valid", bus.matrix_valid, 0);
        bus.elem_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        v = '{32'd5, 32'd0, 32'd0, 32'd0, 32'd5, 32'd0, 32'd0, 32'd0, 32'd5};
        run("after reset", v, 1'b0, 1'b0, 0, 32'd125);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
